pdm_cic_decim: RTL and testbench
================================

PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 Parameter DECIM, default 64: decimation ratio, power of two, 8..64.
REQ-002 Parameter NSAMP, default 1024: PCM samples written per capture, 1..65536.
REQ-003 Parameter SKIP, default 3: initial decimated outputs discarded per capture (filter transient).
REQ-004 clk  in  1  the only clock, PDM bit clock domain.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 start  in  1  one-cycle pulse; begins a capture when idle.
REQ-007 pdm_bit  in  1  PDM microphone data bit.
REQ-008 bit_vld  in  1  pdm_bit is valid this cycle; the bit is accepted only when high.
REQ-009 pcm  out  16  signed PCM sample for the buffer write port.
REQ-010 we  out  1  one-cycle write strobe for pcm/waddr.
REQ-011 waddr  out  16  buffer word index of the current write.
REQ-012 bsy  out  1  high from the accepted start until capture completes.
REQ-013 done  out  1  one-cycle pulse after the last write.

Function
REQ-014 Filter: 3rd-order CIC, differential delay 1, ratio DECIM; input mapping pdm_bit=1 -> +1, 0 -> -1.
REQ-015 Arithmetic: three integrators and three combs, each 20-bit two's complement; wrap-around overflow is intended and not saturated.
REQ-016 Integrators update only on cycles with bit_vld=1 and state CAPTURE or SETTLE; otherwise they hold.
REQ-017 A phase counter (log2 DECIM bits) counts accepted bits; on the accepted bit that takes it from DECIM-1 to 0, combs evaluate the updated integrator-3 value and register the result.
REQ-018 pcm = comb3 result bits [19:4] (gain DECIM^3 = 2^18 at DECIM=64), registered; pcm is valid on the cycle after the DECIM-th accepted bit.
REQ-019 FSM states: IDLE, SETTLE, CAPTURE, DONE.
REQ-020 IDLE: bsy=0; start=1 -> clear integrators, combs, phase, skip count, and waddr; go to SETTLE.
REQ-021 SETTLE: decimated outputs are counted, not written; after the SKIP-th output go to CAPTURE. SKIP=0 goes directly to CAPTURE.
REQ-022 CAPTURE: each decimated output drives we=1 for one cycle with the current waddr; waddr increments the cycle after each write.
REQ-023 After write NSAMP-1 (waddr = NSAMP-1), go to DONE; no further writes occur.
REQ-024 DONE: done=1 for exactly one cycle, bsy=0 in the same cycle, then IDLE.
REQ-025 start while bsy=1 is ignored; start in the DONE cycle is ignored.
REQ-026 bit_vld gaps of any length stall the filter without loss; phase and sums persist across the gap.
REQ-027 Filter state between captures is irrelevant, because start clears it.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE; pcm=0, we=0, waddr=0, bsy=0, done=0; all integrators, combs, and counters are 0.
REQ-029 rst overrides start and bit_vld in the same cycle; reset mid-capture aborts with no further we and no done pulse.

Verification
REQ-030 DECIM=64, SKIP=3, NSAMP=8, bit_vld=1 continuously, pdm_bit=1 -> 8 writes, waddr 0..7, every pcm = 16384 (0x4000), then done for one cycle.
REQ-031 Same setup, pdm_bit=0 -> 8 writes, every pcm = -16384 (0xC000).
REQ-032 Same setup, pdm_bit alternating 1,0 -> every written pcm = 0.
REQ-033 bit_vld high one cycle in four, pdm_bit=1 -> same pcm values as REQ-030; write spacing = 256 clk cycles.
REQ-034 Second start pulse mid-capture -> ignored: 8 writes total, waddr does not restart.
REQ-035 rst asserted after write 3 -> next cycle we=0, bsy=0, waddr=0, no done pulse; a later start produces a full, correct capture.

Source files
------------

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: 3rd-order CIC decimator turning a PDM bitstream into a fixed-length PCM capture
module pdm_cic_decim #(
  parameter int DECIM = 64,
  parameter int NSAMP = 1024,
  parameter int SKIP  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pdm_bit,
  input  logic        bit_vld,
  output logic [15:0] pcm,
  output logic        we,
  output logic [15:0] waddr,
  output logic        bsy,
  output logic        done
);
  localparam int PW = $clog2(DECIM);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
  state_t state;
  logic [19:0] i1, i2, i3, d1, d2, d3;
  logic [19:0] n1, n2, n3, c1, c2, c3;
  logic [PW-1:0] phase;
  logic [15:0] skip_cnt;
  logic acc, dec;
  // next integrator values and comb outputs for the bit being accepted this cycle
  always_comb begin
    acc = bit_vld && (state == SETTLE || state == CAPTURE);
    dec = acc && phase == PW'(DECIM - 1);
    n1 = i1 + (pdm_bit ? 20'd1 : 20'hfffff);
    n2 = i2 + n1;
    n3 = i3 + n2;
    c1 = n3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end
  // filter state, capture sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {i1, i2, i3, d1, d2, d3} <= '0;
      phase <= '0;
      skip_cnt <= '0;
      pcm <= '0;
      we <= 1'b0;
      waddr <= '0;
      bsy <= 1'b0;
      done <= 1'b0;
    end else begin
      we <= 1'b0;
      done <= 1'b0;
      if (we) waddr <= waddr + 16'd1;
      if (acc) begin
        i1 <= n1;
        i2 <= n2;
        i3 <= n3;
        phase <= phase + 1'b1;
      end
      if (dec) begin
        d1 <= n3;
        d2 <= c1;
        d3 <= c2;
      end
      case (state)
        IDLE: if (start && !done) begin
          {i1, i2, i3, d1, d2, d3} <= '0;
          phase <= '0;
          skip_cnt <= '0;
          waddr <= '0;
          bsy <= 1'b1;
          state <= (SKIP == 0) ? CAPTURE : SETTLE;
        end
        SETTLE: if (dec) begin
          skip_cnt <= skip_cnt + 16'd1;
          if (skip_cnt == 16'(SKIP - 1)) state <= CAPTURE;
        end
        CAPTURE: if (dec) begin
          we <= 1'b1;
          pcm <= 16'(c3 >> 4);
          if (waddr == 16'(NSAMP - 1)) state <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          bsy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdm_cic_decim.sv
// tb_pdm_cic_decim: randomized captures checked against a direct-convolution CIC model
module tb_pdm_cic_decim;
  localparam int DECIM = 64, NSAMP = 8, SKIP = 3, HL = 3 * DECIM - 2, LIM = 20000;
  logic clk = 0, rst, start, pdm_bit, bit_vld;
  logic [15:0] pcm, waddr;
  logic we, bsy, done;
  int h[HL];
  int xq[$];
  int npass = 0, nchk = 0;
  int wcnt, dcnt, cyc_n = 0, last_w, gap_exp, fixed_val;
  bit cap = 0, fixed_on;

  pdm_cic_decim #(.DECIM(DECIM), .NSAMP(NSAMP), .SKIP(SKIP)) dut (
    .clk(clk), .rst(rst), .start(start), .pdm_bit(pdm_bit), .bit_vld(bit_vld),
    .pcm(pcm), .we(we), .waddr(waddr), .bsy(bsy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  // decimated output k (1-based) is the boxcar^3 FIR evaluated at accepted bit DECIM*k-1
  function automatic int model(input int k);
    int n, y;
    logic [19:0] w;
    n = DECIM * k - 1;
    y = 0;
    for (int t = 0; t < HL; t++)
      if (n - t >= 0 && n - t < xq.size()) y += h[t] * xq[n - t];
    w = 20'(y);
    return int'($signed(w[19:4]));
  endfunction

  always @(negedge clk) if (cap) begin
    if (we) begin
      chk("waddr", int'(waddr), wcnt);
      chk("pcm_model", int'($signed(pcm)), model(wcnt + SKIP + 1));
      if (fixed_on) chk("pcm_fixed", int'($signed(pcm)), fixed_val);
      if (gap_exp > 0 && wcnt > 0) chk("write_gap", cyc_n - last_w, gap_exp);
      last_w = cyc_n;
      wcnt++;
    end
    if (done) begin
      dcnt++;
      chk("done_bsy", int'(bsy), 0);
    end
  end

  task automatic capture(input int mode, input int vmode, input bit mid_start, input bit done_start, input int abort_at);
    int n;
    bit sent, v, p, seen;
    xq.delete();
    wcnt = 0; dcnt = 0; cap = 1; n = 0; sent = 0;
    gap_exp = vmode == 0 ? DECIM : vmode == 1 ? 4 * DECIM : 0;
    @(negedge clk); start = 1; bit_vld = 0;
    @(negedge clk); start = 0;
    chk("bsy_start", int'(bsy), 1);
    while (!done && n < LIM) begin
      if (abort_at > 0 && we && waddr == 16'(abort_at - 1)) break;
      v = vmode == 0 ? 1'b1 : vmode == 1 ? (n % 4 == 0) : vmode == 2 ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      p = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : mode == 2 ? (xq.size() % 2 == 0) : ($urandom_range(1) == 1);
      bit_vld = v; pdm_bit = p;
      if (v) xq.push_back(p ? 1 : -1);
      start = mid_start && !sent && we && waddr == 16'd2;
      if (start) sent = 1;
      n++;
      @(negedge clk);
    end
    start = 0; bit_vld = 0;
    if (n >= LIM) begin
      chk("timeout", 0, 1);
      cap = 0;
      return;
    end
    if (abort_at > 0) begin
      rst = 1;
      @(negedge clk); rst = 0; cap = 0;
      chk("abort_we", int'(we), 0);
      chk("abort_bsy", int'(bsy), 0);
      chk("abort_waddr", int'(waddr), 0);
      chk("abort_pcm", int'(pcm), 0);
      seen = 0;
      repeat (400) begin
        bit_vld = 1; pdm_bit = 1'($urandom_range(1));
        @(negedge clk);
        seen |= we | done;
      end
      bit_vld = 0;
      chk("abort_quiet", int'(seen), 0);
      return;
    end
    if (done_start) start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    if (done_start) chk("done_start_ign", int'(bsy), 0);
    chk("write_count", wcnt, NSAMP);
    chk("done_pulses", dcnt, 1);
    chk("bsy_end", int'(bsy), 0);
    cap = 0;
  endtask

  initial begin
    for (int i = 0; i < DECIM; i++)
      for (int j = 0; j < DECIM; j++)
        for (int k = 0; k < DECIM; k++) h[i + j + k]++;
    rst = 1; start = 1; pdm_bit = 0; bit_vld = 1;
    repeat (3) @(negedge clk);
    chk("rst_pcm", int'(pcm), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_bsy", int'(bsy), 0);
    chk("rst_done", int'(done), 0);
    rst = 0; start = 0; bit_vld = 0;
    @(negedge clk);
    fixed_on = 1;
    fixed_val = 16384;  capture(0, 0, 0, 0, 0);
    fixed_val = -16384; capture(1, 0, 0, 0, 0);
    fixed_val = 0;      capture(2, 0, 0, 0, 0);
    fixed_val = 16384;  capture(0, 1, 0, 0, 0);
    fixed_on = 0;
    capture(3, 2, 1, 1, 0);
    capture(3, 0, 0, 0, 3);
    capture(3, 0, 0, 0, 0);
    capture(3, 3, 0, 0, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
